// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin scheduler that shares one AES_top core between two
// valid/ready requesters, with a watchdog that aborts jobs the core never finishes.
module aes_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_data,
  input  logic [127:0]     req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_data,
  input  logic [127:0]     req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             core_en,
  output logic [127:0]     core_data_in,
  output logic [127:0]     core_key_in,
  input  logic [127:0]     core_data_out,
  input  logic             core_data_out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  logic             last_id;
  logic [TMO_W-1:0] tmo_cnt;
  logic             grant0;
  logic             grant1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_id;
      grant1 = ~last_id;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state        <= IDLE;
      last_id      <= 1'b1;
      tmo_cnt      <= '0;
      core_en      <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      job_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            core_data_in <= req1_ready ? req1_data : req0_data;
            core_key_in  <= req1_ready ? req1_key  : req0_key;
            rsp_id       <= req1_ready;
            last_id      <= req1_ready;
            tmo_cnt      <= '0;
            core_en      <= 1'b1;
            busy         <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A result on the timeout cycle still counts as a good result.
          if (core_data_out_valid) begin
            rsp_data  <= core_data_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= RESP;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            job_count <= job_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: behavioural AES core stub, cycle model of the
// scheduling rules, directed scenarios and a randomized two-requester run.
module tb_aes_req_arbiter;

  localparam int unsigned T  = 64;
  localparam int unsigned CW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [127:0]   req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic           rsp_valid, rsp_ready = 1'b1;
  logic [127:0]   rsp_data;
  logic           rsp_id, rsp_err;
  logic           core_en;
  logic [127:0]   core_data_in, core_key_in;
  logic [127:0]   core_data_out = '0;
  logic           core_data_out_valid = 1'b0;
  logic           busy;
  logic [CW-1:0]  job_count;

  aes_req_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .AES_clk(clk), .AES_rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .core_en(core_en), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, want event", name);
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [0:255];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- core stub ----------------
  int en_cycles = 0, cur_lat = 0, core_lat = 5;
  bit force_valid = 0, rand_mode = 0;

  always @(posedge clk) begin
    #2;
    if (core_en) en_cycles++; else en_cycles = 0;
    if (!rand_mode) cur_lat = core_lat;
    else if (en_cycles == 1) cur_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
    if (core_en && cur_lat != 0 && en_cycles == cur_lat) begin
      core_data_out_valid = 1'b1;
      core_data_out       = aes_enc(core_data_in, core_key_in);
    end else if (force_valid || (rand_mode && !core_en && $urandom_range(0, 7) == 0)) begin
      core_data_out_valid = 1'b1;
      core_data_out       = rand128();
    end else begin
      core_data_out_valid = 1'b0;
      core_data_out       = '0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit            m_init = 0, m_act = 0, m_pend = 0, m_last = 1, m_jid = 0, m_rid = 0, m_rerr = 0;
  bit            m_g0, m_g1, m_idle;
  int            m_bcyc = 0;
  logic [127:0]  m_rdata = '0, m_cdin = '0, m_ckey = '0;
  logic [CW-1:0] m_cnt = '0;

  always @(negedge clk) begin
    m_idle = !m_act && !m_pend;
    m_g0   = req0_valid && (!req1_valid || m_last);
    m_g1   = req1_valid && (!req0_valid || !m_last);
    if (m_init) begin
      chk("req0_ready",   128'(req0_ready),   128'(m_idle && m_g0));
      chk("req1_ready",   128'(req1_ready),   128'(m_idle && m_g1));
      chk("busy",         128'(busy),         128'(!m_idle));
      chk("core_en",      128'(core_en),      128'(m_act));
      chk("rsp_valid",    128'(rsp_valid),    128'(m_pend));
      chk("core_data_in", core_data_in,       m_cdin);
      chk("core_key_in",  core_key_in,        m_ckey);
      chk("job_count",    128'(job_count),    128'(m_cnt));
      if (m_pend) begin
        chk("rsp_data", rsp_data,      m_rdata);
        chk("rsp_id",   128'(rsp_id),  128'(m_rid));
        chk("rsp_err",  128'(rsp_err), 128'(m_rerr));
      end
    end
    if (rst) begin
      m_init = 1; m_act = 0; m_pend = 0; m_last = 1; m_rid = 0; m_rerr = 0;
      m_rdata = '0; m_cdin = '0; m_ckey = '0; m_cnt = '0;
    end else if (m_init) begin
      if (m_act) begin
        m_bcyc++;
        if (core_data_out_valid) begin
          m_act = 0; m_pend = 1; m_rdata = core_data_out; m_rerr = 0; m_rid = m_jid;
        end else if (m_bcyc == int'(T)) begin
          m_act = 0; m_pend = 1; m_rdata = '0; m_rerr = 1; m_rid = m_jid;
        end
      end else if (m_pend) begin
        if (rsp_ready) begin m_pend = 0; m_cnt = m_cnt + 1'b1; end
      end else if (m_g0 || m_g1) begin
        m_jid  = m_g1;
        m_last = m_g1;
        m_cdin = m_g1 ? req1_data : req0_data;
        m_ckey = m_g1 ? req1_key  : req0_key;
        m_act  = 1;
        m_bcyc = 0;
      end
    end
  end

  // ---------------- response log and expected results ----------------
  typedef struct { logic id; logic err; logic [127:0] data; } rsp_t;
  rsp_t         rsp_q[$];
  logic [127:0] exp_q0[$], exp_q1[$];

  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) rsp_q.push_back('{rsp_id, rsp_err, rsp_data});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit id, input logic [127:0] d, input logic [127:0] k);
    int n;
    n = 0;
    if (id) begin req1_data = d; req1_key = k; req1_valid = 1'b1; exp_q1.push_back(aes_enc(d, k)); end
    else    begin req0_data = d; req0_key = k; req0_valid = 1'b1; exp_q0.push_back(aes_enc(d, k)); end
    forever begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) break;
      if (++n > 2000) begin fail_bound("send_wait"); break; end
    end
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input int bound);
    int c;
    c = 0;
    while (rsp_q.size() < n) begin
      @(negedge clk);
      if (++c > bound) begin fail_bound("rsp_wait"); break; end
    end
  endtask

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #600000;
    $display("FAIL global_watchdog: got no end of test, want end of test");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rsp_t         r;
    logic [127:0] d, k, e, da, ka, db, kb;
    logic         id_s, err_s;
    int           en_cyc, c;

    init_sbox();
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",      128'(busy),      '0);
    chk("rst_core_en",   128'(core_en),   '0);
    chk("rst_rsp_valid", 128'(rsp_valid), '0);
    chk("rst_rsp_data",  rsp_data,        '0);
    chk("rst_rsp_id",    128'(rsp_id),    '0);
    chk("rst_rsp_err",   128'(rsp_err),   '0);
    chk("rst_job_count", 128'(job_count), '0);
    chk("rst_core_data", core_data_in,    '0);
    chk("rst_core_key",  core_key_in,     '0);
    chk("aes_kat", aes_enc(KAT_PT, KAT_KEY), KAT_CT);

    // single job through the AES reference core
    tick();
    core_lat = 10;
    send(0, KAT_PT, KAT_KEY);
    wait_q(1, 200);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("single_data", r.data, KAT_CT);
      chk("single_id",   128'(r.id),  '0);
      chk("single_err",  128'(r.err), '0);
    end
    tick();
    @(negedge clk);
    chk("single_job_count", 128'(job_count), 128'(1));

    // timeout on requester 1
    tick();
    core_lat = 0;
    send(1, rand128(), rand128());
    en_cyc = 0; c = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      if (core_en && !rsp_valid) en_cyc++;
      if (++c > 300) begin fail_bound("timeout_wait"); break; end
    end
    chk("timeout_latency", 128'(en_cyc),  128'(T));
    chk("timeout_core_en", 128'(core_en), '0);
    chk("timeout_err",     128'(rsp_err), 128'(1));
    chk("timeout_data",    rsp_data,      '0);
    chk("timeout_id",      128'(rsp_id),  128'(1));
    tick(); tick();

    // response backpressure with spurious core valids
    rsp_q.delete();
    core_lat = 3; rsp_ready = 1'b0;
    send(0, rand128(), rand128());
    c = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      if (++c > 100) begin fail_bound("bp_wait"); break; end
    end
    d = rsp_data; id_s = rsp_id; err_s = rsp_err;
    tick();
    req1_data = rand128(); req1_key = rand128(); req1_valid = 1'b1;
    exp_q1.push_back(aes_enc(req1_data, req1_key));
    for (int i = 0; i < 10; i++) begin
      force_valid = (i % 3 == 0);
      tick();
      @(negedge clk);
      chk("bp_rsp_valid", 128'(rsp_valid),  128'(1));
      chk("bp_rsp_data",  rsp_data,         d);
      chk("bp_rsp_id",    128'(rsp_id),     128'(id_s));
      chk("bp_rsp_err",   128'(rsp_err),    128'(err_s));
      chk("bp_req1_ready", 128'(req1_ready), '0);
    end
    tick();
    force_valid = 1'b0; rsp_ready = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (req1_ready) break;
      if (++c > 100) begin fail_bound("bp_accept_wait"); break; end
    end
    tick();
    req1_valid = 1'b0;
    wait_q(2, 200);
    tick(); tick();
    force_valid = 1'b1;
    repeat (3) tick();
    force_valid = 1'b0;
    tick();

    // result arriving on the timeout cycle
    rsp_q.delete();
    core_lat = int'(T);
    d = rand128(); k = rand128();
    send(0, d, k);
    wait_q(1, 300);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("collide_err",  128'(r.err), '0);
      chk("collide_data", r.data,      aes_enc(d, k));
    end
    tick(); tick();

    // reset in the 5th BUSY cycle, then a late core valid
    rsp_q.delete();
    core_lat = 0;
    send(1, rand128(), rand128());
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; force_valid = 1'b1;
    @(negedge clk);
    chk("midrst_core_en",   128'(core_en),   '0);
    chk("midrst_busy",      128'(busy),      '0);
    chk("midrst_rsp_valid", 128'(rsp_valid), '0);
    chk("midrst_job_count", 128'(job_count), '0);
    tick();
    force_valid = 1'b0;
    repeat (5) tick();
    chk("midrst_no_rsp", 128'(rsp_q.size()), '0);

    // simultaneous requests right after reset
    exp_q0.delete(); exp_q1.delete();
    core_lat = 5;
    da = rand128(); ka = rand128(); db = rand128(); kb = rand128();
    fork
      send(0, da, ka);
      send(1, db, kb);
    join
    wait_q(2, 300);
    if (rsp_q.size() >= 2) begin
      r = rsp_q.pop_front();
      chk("simul_first_id",    128'(r.id), '0);
      chk("simul_first_data",  r.data,     aes_enc(da, ka));
      r = rsp_q.pop_front();
      chk("simul_second_id",   128'(r.id), 128'(1));
      chk("simul_second_data", r.data,     aes_enc(db, kb));
    end
    tick(); tick();

    // randomized traffic on both requesters
    rsp_q.delete(); exp_q0.delete(); exp_q1.delete();
    rand_mode = 1;
    fork
      begin
        while (rsp_q.size() < 30 && c < 100000) begin
          tick();
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        fork
          for (int j = 0; j < 15; j++) begin
            repeat ($urandom_range(0, 4)) tick();
            send(0, rand128(), rand128());
          end
          for (int j = 0; j < 15; j++) begin
            repeat ($urandom_range(0, 4)) tick();
            send(1, rand128(), rand128());
          end
        join
        wait_q(30, 6000);
        c = 100000;
      end
    join
    rsp_ready = 1'b1;
    rand_mode = 0;
    foreach (rsp_q[i]) begin
      e = '0;
      if (rsp_q[i].id && exp_q1.size() > 0) e = exp_q1.pop_front();
      else if (!rsp_q[i].id && exp_q0.size() > 0) e = exp_q0.pop_front();
      if (rsp_q[i].err) e = '0;
      chk("rnd_rsp_data", rsp_q[i].data, e);
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
